fifo_cam: RTL and testbench
===========================

FIFO_CAM -- requirements
Module: fifo_cam

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17, meaning entry width (bit 16 is the command flag, bits 15:0 are pixel data).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of depth (1024 entries).
REQ-003 SHALL have port clk, input, 1, write-domain clock.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous, active-low; resets both domains.
REQ-005 SHALL have port rd_clk, input, 1, read-domain clock, asynchronous to clk.
REQ-006 SHALL have port data, input, DATA_WIDTH, write data sampled on clk rising edge.
REQ-007 SHALL have port wr_en, input, 1, write request (clk domain).
REQ-008 SHALL have port rd_en, input, 1, read request (rd_clk domain).
REQ-009 SHALL have port q, output, DATA_WIDTH, registered read data (rd_clk domain).
REQ-010 SHALL have port empty, output, 1, no readable entry (rd_clk domain).
REQ-011 SHALL have port full, output, 1, no writable slot (clk domain).

Function
REQ-012 SHALL store entries in a 2^ADDR_WIDTH x DATA_WIDTH dual-clock memory; write port on clk, read port on rd_clk.
REQ-013 SHALL keep binary and Gray-coded write/read pointers of ADDR_WIDTH+1 bits; the MSB distinguishes wrap for full detection.
REQ-014 SHALL pass each Gray pointer to the opposite domain through a 2-flop synchronizer; no binary pointer crosses domains.
REQ-015 SHALL write data at wr_ptr and increment wr_ptr on a clk rising edge when wr_en=1 and full=0.
REQ-016 SHALL ignore wr_en while full=1 and leave memory and pointers unchanged.
REQ-017 SHALL use standard (non-fall-through) reads: on an rd_clk rising edge with rd_en=1 and empty=0, load q with mem[rd_ptr] and increment rd_ptr.
REQ-018 SHALL hold q unchanged when rd_en=0 or empty=1; a read on empty SHALL NOT move rd_ptr.
REQ-019 SHALL register empty in the rd_clk domain.
REQ-020 SHALL set empty=1 when the next read Gray pointer equals the synchronized write Gray pointer.
REQ-021 SHALL deassert empty no later than 3 rd_clk edges after the first write becomes stable.
REQ-022 SHALL register full in the clk domain.
REQ-023 SHALL set full=1 when the next write Gray pointer equals the synchronized read Gray pointer with its two MSBs inverted.
REQ-024 SHALL make empty and full conservative: empty may lag writes and full may lag reads, but a read SHALL never return an unwritten entry and a write SHALL never overwrite an unread entry.
REQ-025 SHALL let the last read set empty=1 at the same rd_clk edge that presents the last entry on q.
REQ-026 SHALL return entries in exact write order across pointer wrap-around.
REQ-027 SHALL handle simultaneous read and write on the same cycle independently, each governed by its own flag.

Reset
REQ-028 SHALL respond to reset_n=0 immediately: clear all pointers and synchronizers, q=0, empty=1, full=0.
REQ-029 SHALL release reset synchronously in each domain through a 2-flop reset synchronizer per clock.
REQ-030 SHALL discard all contents when reset is asserted mid-operation; empty=1 and full=0 until new writes.

Verification
REQ-031 SHALL pass: write 0x10000, then 16 random 16-bit words (bit16=0), then 0x10000 -> 18 reads return them in order; after the 18th read q=0x10000 and empty rises on that same rd_clk edge.
REQ-032 SHALL pass: with one entry 0x10000 stored, assert rd_en for one rd_clk edge -> q=0x10000; at the following rd_clk edge empty=1 and q is held.
REQ-033 SHALL pass: 1024 writes with no reads -> full=1 after the 1024th; a 1025th write is ignored; 1024 reads return values 0..1023; then empty=1.
REQ-034 SHALL pass: rd_en held high while empty=1 -> q unchanged and pointers unchanged; the first subsequent write is read correctly.
REQ-035 SHALL pass: pulse reset_n=0 with 10 entries stored -> empty=1, full=0, q=0 at once; the next write/read pair returns only the new value.
REQ-036 SHALL pass: clk period 37.04 ns, rd_clk ~6 ns, 3000 continuous writes with random rd_en -> no loss, no duplication, no reordering.

Source files
------------

// File: rtl/fifo_cam.sv
// fifo_cam: dual-clock FIFO for camera pixel/command words, Gray-pointer CDC
// Ports: clk, data, wr_en, full   - write domain
//        rd_clk, rd_en, q, empty  - read domain
//        reset_n                  - async active-low, released synchronously per domain
// Parameters: DATA_WIDTH (bit 16 = command flag), ADDR_WIDTH (log2 depth)
module fifo_cam #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
    logic [1:0] wr_rst_sync, rd_rst_sync;
    logic wr_rst_n, rd_rst_n;
    logic [ADDR_WIDTH:0] wr_bin, wr_gray, wr_bin_next, wr_gray_next, rq1, rq2;
    logic [ADDR_WIDTH:0] rd_bin, rd_gray, rd_bin_next, rd_gray_next, wq1, wq2;
    logic wr_inc, rd_inc;

    // reset asserts immediately, deasserts two edges later in each domain
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wr_rst_sync <= '0;
        else wr_rst_sync <= {wr_rst_sync[0], 1'b1};

    always_ff @(posedge rd_clk or negedge reset_n)
        if (!reset_n) rd_rst_sync <= '0;
        else rd_rst_sync <= {rd_rst_sync[0], 1'b1};

    assign wr_rst_n = wr_rst_sync[1];
    assign rd_rst_n = rd_rst_sync[1];

    always_comb begin
        wr_inc = wr_en && !full;
        wr_bin_next = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_inc};
        wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
        rd_inc = rd_en && !empty;
        rd_bin_next = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_inc};
        rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    end

    // full compares against a stale read pointer, so it can only lag reads
    always_ff @(posedge clk or negedge wr_rst_n)
        if (!wr_rst_n) begin
            wr_bin <= '0;
            wr_gray <= '0;
            rq1 <= '0;
            rq2 <= '0;
            full <= 1'b0;
        end else begin
            wr_bin <= wr_bin_next;
            wr_gray <= wr_gray_next;
            rq1 <= rd_gray;
            rq2 <= rq1;
            full <= wr_gray_next == {~rq2[ADDR_WIDTH -: 2], rq2[ADDR_WIDTH-2:0]};
        end

    always_ff @(posedge clk)
        if (wr_inc) mem[wr_bin[ADDR_WIDTH-1:0]] <= data;

    // empty uses the post-read pointer so the last read raises it on the same edge
    always_ff @(posedge rd_clk or negedge rd_rst_n)
        if (!rd_rst_n) begin
            rd_bin <= '0;
            rd_gray <= '0;
            wq1 <= '0;
            wq2 <= '0;
            empty <= 1'b1;
            q <= '0;
        end else begin
            rd_bin <= rd_bin_next;
            rd_gray <= rd_gray_next;
            wq1 <= wr_gray;
            wq2 <= wq1;
            empty <= rd_gray_next == wq2;
            if (rd_inc) q <= mem[rd_bin[ADDR_WIDTH-1:0]];
        end
endmodule

// File: tb/tb_fifo_cam.sv
// tb_fifo_cam: directed checks plus queue reference model for fifo_cam
`timescale 1ns/1ps
module tb_fifo_cam;
    localparam int DW = 17;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rd_clk = 1'b0;
    logic reset_n = 1'b0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] q;
    logic empty, full;

    always #18.52 clk = ~clk;
    always #3 rd_clk = ~rd_clk;

    fifo_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rd_clk(rd_clk),
        .data(data),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .q(q),
        .empty(empty),
        .full(full)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // reference: contents are exactly the accepted writes not yet read
    always @(negedge reset_n) begin
        model.delete();
        exp_q = '0;
    end

    always @(posedge clk) begin
        if (reset_n && wr_en && !full) begin
            model.push_back(data);
            n_push++;
        end
        #1;
        if (reset_n && model.size() >= DEPTH) begin
            chk("full_when_model_full", full, 1);
            chk("no_overwrite", model.size(), DEPTH);
        end
    end

    always @(posedge rd_clk) begin
        if (reset_n && rd_en && !empty) begin
            chk("read_has_data", model.size() > 0, 1);
            if (model.size() > 0) exp_q = model.pop_front();
            n_pop++;
        end
        #1;
        if (reset_n) begin
            chk("q_model", q, exp_q);
            if (model.size() == 0) chk("empty_model", empty, 1);
        end
    end

    task automatic wr(input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        data = d;
    endtask

    task automatic wr_idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(output logic [DW-1:0] v);
        int n = 0;
        @(negedge rd_clk);
        while (empty && n < 100) begin
            @(negedge rd_clk);
            n++;
        end
        chk("rd_wait_nonempty", empty, 0);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        v = q;
        @(negedge rd_clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] vec[18];
        int n, push0, pop0;
        logic done;
        #50;
        chk("rst_q", q, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        #50 reset_n = 1'b1;
        repeat (4) @(negedge clk);

        vec[0] = 17'h10000;
        for (int i = 1; i < 17; i++) vec[i] = {1'b0, 16'($urandom)};
        vec[17] = 17'h10000;
        for (int i = 0; i < 18; i++) wr(vec[i]);
        wr_idle();
        for (int i = 0; i < 18; i++) begin
            rd(v);
            chk("seq_order", v, vec[i]);
        end
        chk("seq_last_q", q, 17'h10000);
        chk("seq_last_empty", empty, 1);

        wr(17'h10000);
        wr_idle();
        rd(v);
        chk("one_q", v, 17'h10000);
        chk("one_empty_same_edge", empty, 1);
        @(posedge rd_clk);
        #1;
        chk("one_empty_next", empty, 1);
        chk("one_q_held", q, 17'h10000);

        for (int i = 0; i < DEPTH; i++) wr(17'(i));
        @(posedge clk);
        #1;
        chk("fill_full", full, 1);
        wr(17'h1ABCD);
        wr_idle();
        repeat (5) @(negedge clk);
        chk("fill_full_hold", full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(v);
            chk("fill_val", v, 17'(i));
        end
        chk("fill_drained_empty", empty, 1);

        @(negedge rd_clk);
        rd_en = 1'b1;
        repeat (20) begin
            @(posedge rd_clk);
            #1;
            chk("empty_rd_q_held", q, 17'h003FF);
            chk("empty_rd_flag", empty, 1);
        end
        wr(17'h00055);
        wr_idle();
        n = 0;
        while (q == 17'h003FF && n < 50) begin
            @(posedge rd_clk);
            #1;
            n++;
        end
        chk("after_empty_q", q, 17'h00055);
        chk("after_empty_flag", empty, 1);
        @(negedge rd_clk);
        rd_en = 1'b0;

        for (int i = 0; i < 10; i++) wr(17'h100 + 17'(i));
        wr_idle();
        rd(v);
        chk("pre_rst_q", v, 17'h100);
        repeat (10) @(negedge rd_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_full", full, 0);
        #40 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("postrst_empty", empty, 1);
        wr(17'h01234);
        wr_idle();
        rd(v);
        chk("postrst_q", v, 17'h01234);
        chk("postrst_empty_after", empty, 1);

        push0 = n_push;
        pop0 = n_pop;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) wr({1'b0, 16'(i * 7 + 3)});
                wr_idle();
                done = 1'b1;
            end
            begin
                int k = 0;
                while ((!done || model.size() > 0) && k < 60000) begin
                    @(negedge rd_clk);
                    rd_en = 1'($urandom_range(0, 1));
                    k++;
                end
                @(negedge rd_clk);
                rd_en = 1'b0;
            end
        join
        repeat (4) @(negedge rd_clk);
        chk("stream_written", n_push - push0, 3000);
        chk("stream_read", n_pop - pop0, 3000);
        chk("stream_model_empty", model.size(), 0);
        chk("stream_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
